// File: rtl/spi_word_packer_if.sv
// spi_word_packer_if: byte-stream, status and word-stream signals of the SPI word packer
interface spi_word_packer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_WIDTH     = 3
);
  logic [DATA_WIDTH-1:0]                spi_data_receive;
  logic                                 spi_ready;
  logic                                 cs;
  logic [DATA_WIDTH-1:0]                spi_data_send;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [ADDR_WIDTH:0]                  level;
  logic                                 overflow;
  logic                                 clear_overflow;
  modport master (
    output spi_data_receive, spi_ready, cs, out_ready, clear_overflow,
    input  spi_data_send, out_data, out_valid, level, overflow
  );
  modport slave (
    input  spi_data_receive, spi_ready, cs, out_ready, clear_overflow,
    output spi_data_send, out_data, out_valid, level, overflow
  );
endinterface

// File: rtl/spi_word_packer.sv
// spi_word_packer: packs SPI bytes MSB-first into words, buffers them in a FWFT FIFO, reports status
module spi_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_WIDTH     = 3
) (
  input logic clk,
  input logic rst,
  spi_word_packer_if.slave bus
);
  localparam int W     = DATA_WIDTH * BYTES_PER_WORD;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(BYTES_PER_WORD);
  logic                  ready_q, cs_q, overflow;
  logic                  rise, take, push, full, pop, wr_ok, drop;
  logic [CW-1:0]         byte_cnt;
  logic [W-DATA_WIDTH-1:0] shift;
  logic [W-1:0]          word;
  logic [W-1:0]          mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] send;
  // Strobe/abort detection and FIFO push/pop decisions; a strobe coinciding with a cs rise still counts
  always_comb begin
    rise  = bus.cs & ~cs_q;
    take  = bus.spi_ready & ~ready_q & (~bus.cs | rise);
    push  = take & (byte_cnt == CW'(BYTES_PER_WORD - 1));
    full  = cnt == (ADDR_WIDTH+1)'(DEPTH);
    pop   = (cnt != '0) & bus.out_ready;
    wr_ok = push & (~full | pop);
    drop  = push & full & ~pop;
    word  = {shift, bus.spi_data_receive};
  end
  // Byte assembly; ready_q/cs_q reset high so levels held at reset release raise no event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b1;
      cs_q     <= 1'b1;
      byte_cnt <= '0;
      shift    <= '0;
    end else begin
      ready_q <= bus.spi_ready;
      cs_q    <= bus.cs;
      if (push || rise) byte_cnt <= '0;
      else if (take) byte_cnt <= byte_cnt + 1'b1;
      if (take) shift <= word[W-DATA_WIDTH-1:0];
    end
  end
  // FIFO pointers, fill count, sticky overflow (set beats clear) and the status byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      send     <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt      <= cnt + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(pop);
      overflow <= drop | (overflow & ~bus.clear_overflow);
      send     <= {overflow, (DATA_WIDTH-1)'(cnt)};
    end
  end
  // Word storage; contents need no reset because empty reads are forced to zero
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= word;
  end
  assign bus.out_data      = (cnt == '0) ? '0 : mem[rd_ptr];
  assign bus.out_valid     = cnt != '0;
  assign bus.level         = cnt;
  assign bus.overflow      = overflow;
  assign bus.spi_data_send = send;
endmodule

// File: tb/tb_spi_word_packer.sv
// tb_spi_word_packer: directed table-driven checks of the SPI word packer
module tb_spi_word_packer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  typedef struct {
    logic [31:0] word;
    logic [3:0]  lvl;
    logic        ovf;
  } vec_t;
  vec_t tbl [9];
  spi_word_packer_if bus ();
  spi_word_packer dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.spi_data_receive = b;
    bus.spi_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.spi_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask
  task automatic pop_chk(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk(name, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    tbl[0] = '{32'h01010101, 4'd1, 1'b0};
    tbl[1] = '{32'h02020202, 4'd2, 1'b0};
    tbl[2] = '{32'h03030303, 4'd3, 1'b0};
    tbl[3] = '{32'h04040404, 4'd4, 1'b0};
    tbl[4] = '{32'h05050505, 4'd5, 1'b0};
    tbl[5] = '{32'h06060606, 4'd6, 1'b0};
    tbl[6] = '{32'h07070707, 4'd7, 1'b0};
    tbl[7] = '{32'h08080808, 4'd8, 1'b0};
    tbl[8] = '{32'h09090909, 4'd8, 1'b1};
    rst = 1'b1;
    bus.spi_ready = 1'b1;
    bus.spi_data_receive = 8'h5a;
    bus.cs = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_send", 32'(bus.spi_data_send), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.spi_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("release_level", 32'(bus.level), 32'd0);
    chk("release_send", 32'(bus.spi_data_send), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    bus.spi_data_receive = 8'h44;
    bus.spi_ready = 1'b1;
    chk("pre_strobe_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", bus.out_data, 32'h11223344);
    chk("lat_level", 32'(bus.level), 32'd1);
    repeat (4) @(negedge clk);
    bus.spi_ready = 1'b0;
    @(negedge clk);
    chk("t2_send", 32'(bus.spi_data_send), 32'h01);
    chk("t2_level_held", 32'(bus.level), 32'd1);
    pop_chk("t2_pop", 32'h11223344);
    chk("t2_empty", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 9; i++) begin
      send_word(tbl[i].word);
      chk($sformatf("fill%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
      chk($sformatf("fill%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
      chk($sformatf("fill%0d_head", i), bus.out_data, tbl[0].word);
    end
    chk("t3_send", 32'(bus.spi_data_send), 32'h88);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t3_pop%0d", i), tbl[i].word);
    chk("t3_drained", 32'(bus.out_valid), 32'd0);
    chk("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    bus.clear_overflow = 1'b1;
    @(negedge clk);
    bus.clear_overflow = 1'b0;
    chk("t3_ovf_clear", 32'(bus.overflow), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    bus.cs = 1'b1;
    send_byte(8'hEE);
    bus.cs = 1'b0;
    send_word(32'hC1C2C3C4);
    chk("t4_level", 32'(bus.level), 32'd1);
    pop_chk("t4_word", 32'hC1C2C3C4);
    chk("t4_empty", 32'(bus.level), 32'd0);
    send_byte(8'hD1);
    send_byte(8'hD2);
    send_byte(8'hD3);
    @(negedge clk);
    bus.cs = 1'b1;
    bus.spi_data_receive = 8'hD4;
    bus.spi_ready = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (3) @(negedge clk);
    bus.spi_ready = 1'b0;
    @(negedge clk);
    chk("t4b_level", 32'(bus.level), 32'd1);
    pop_chk("t4b_word", 32'hD1D2D3D4);
    send_word(32'h55667788);
    chk("t4b_realign", 32'(bus.out_data), 32'h55667788);
    pop_chk("t4b_pop", 32'h55667788);
    for (int i = 0; i < 8; i++) send_word(tbl[i].word);
    chk("t5_full", 32'(bus.level), 32'd8);
    send_byte(8'h09);
    send_byte(8'h09);
    send_byte(8'h09);
    @(negedge clk);
    bus.spi_data_receive = 8'h09;
    bus.spi_ready = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.spi_ready = 1'b0;
    @(negedge clk);
    chk("t5_level", 32'(bus.level), 32'd8);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < 9; i++) pop_chk($sformatf("t5_pop%0d", i), tbl[i].word);
    chk("t5_empty", 32'(bus.level), 32'd0);
    for (int i = 0; i < 3; i++) send_word(tbl[i].word);
    send_byte(8'hE1);
    send_byte(8'hE2);
    chk("t6_pre_level", 32'(bus.level), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_level", 32'(bus.level), 32'd0);
    chk("t6_data", bus.out_data, 32'd0);
    chk("t6_send", 32'(bus.spi_data_send), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(32'hF1F2F3F4);
    chk("t6_fresh_level", 32'(bus.level), 32'd1);
    pop_chk("t6_fresh_word", 32'hF1F2F3F4);
    chk("t6_final_empty", 32'(bus.out_valid), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
